// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words from a valid/ready byte
// stream and writes them into instruction memory, holding the CPU until the load is done.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DIR_WIDTH  = 10,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8:0]            num_words,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  we,
  output logic [DIR_WIDTH-1:0]  dir,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int              BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int              CNTW  = $clog2(BYTES);
  localparam int              NW    = 9;
  localparam logic [NW-1:0]   MAXW  = NW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [NW-1:0]         word_idx_q, word_idx_d;
  logic [NW-1:0]         n_q, n_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  we_q, we_d;
  logic [DIR_WIDTH-1:0]  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  logic                  accept;
  logic [NW-1:0]         n_clamp;

  assign accept  = byte_ready_q && byte_valid;
  assign n_clamp = (num_words > MAXW) ? MAXW : num_words;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_idx_d   = word_idx_q;
    n_d          = n_q;
    byte_ready_d = byte_ready_q;
    we_d         = 1'b0;
    dir_d        = dir_q;
    data_in_d    = data_in_q;
    busy_d       = busy_q;
    done_d       = done_q;
    cpu_hold_d   = cpu_hold_q;
    checksum_d   = checksum_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d        = n_clamp;
          checksum_d = '0;
          word_idx_d = '0;
          byte_cnt_d = '0;
          word_d     = '0;
          if (n_clamp == '0) begin
            // Empty load: release the CPU straight away.
            state_d      = DONE;
            done_d       = 1'b1;
            busy_d       = 1'b0;
            cpu_hold_d   = 1'b0;
            byte_ready_d = 1'b0;
          end else begin
            state_d      = RECV;
            done_d       = 1'b0;
            busy_d       = 1'b1;
            cpu_hold_d   = 1'b1;
            byte_ready_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (accept) begin
          word_d[int'(byte_cnt_q)*BYTE_WIDTH +: BYTE_WIDTH] = byte_in;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == CNTW'(BYTES-1)) begin
            // Outputs are registered, so the write is set up here and shows in WRITE.
            state_d      = WRITE;
            byte_ready_d = 1'b0;
            we_d         = 1'b1;
            dir_d        = DIR_WIDTH'(32'(word_idx_q) * BYTES);
            data_in_d    = word_d;
          end
        end
      end
      WRITE: begin
        checksum_d = checksum_q + data_in_q;
        word_idx_d = word_idx_q + NW'(1);
        if (word_idx_d == n_q) begin
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          cpu_hold_d   = 1'b0;
          byte_ready_d = 1'b0;
        end else begin
          state_d      = RECV;
          byte_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      word_idx_q   <= '0;
      n_q          <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      dir_q        <= '0;
      data_in_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      word_idx_q   <= word_idx_d;
      n_q          <= n_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      dir_q        <= dir_d;
      data_in_q    <= data_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_hold_q   <= cpu_hold_d;
      checksum_q   <= checksum_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign we         = we_q;
  assign dir        = dir_q;
  assign data_in    = data_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_hold   = cpu_hold_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the main process queues expected imem writes from the
// word list, a negedge monitor pops and checks every we pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [9:0]  dir;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic        cpu_hold;
  logic [31:0] checksum;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .dir(dir), .data_in(data_in), .busy(busy), .done(done),
    .cpu_hold(cpu_hold), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  dir;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] load_words[$];
  logic [31:0] exp_sum;
  logic [31:0] imem[256];
  int          total = 0;
  int          bad   = 0;
  int          we_cnt = 0;
  logic [9:0]  last_dir;
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (we) begin
        we_cnt++;
        last_dir = dir;
        imem[dir[9:2]] = data_in;
        chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_we", {31'd0, we}, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_dir", {22'd0, dir}, {22'd0, e.dir});
          chk("wr_data", data_in, e.data);
        end
      end else if (prev_we && exp_q.size() == 0) begin
        chk("hold_drop_after_last_we", {31'd0, cpu_hold}, 32'd0);
      end
      prev_we = we;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_dir"}, {22'd0, dir}, 32'd0);
    chk({tag, "_data_in"}, data_in, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  // Reference: a load of nw words writes min(nw,256) words at byte address 4*i.
  task automatic model_load(input int nw);
    int n;
    n = (nw > 256) ? 256 : nw;
    exp_sum = 32'd0;
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.dir  = 10'(i * 4);
      e.data = load_words[i];
      exp_q.push_back(e);
      exp_sum = exp_sum + load_words[i];
    end
  endtask

  task automatic pulse_start(input int nw);
    @(posedge clk); #1;
    start = 1'b1;
    num_words = 9'(nw);
    @(posedge clk); #1;
    start = 1'b0;
    num_words = 9'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    bit ok = 0;
    byte_valid = 1'b0;
    repeat ($urandom_range(0, gapmax)) @(posedge clk);
    #1;
    byte_in = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
    if (!ok) chk("byte_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gapmax);
  endtask

  task automatic run_load(input int nw, input int gapmax, input bit mid_start);
    int  n;
    bit  ok = 0;
    n = (nw > 256) ? 256 : nw;
    we_cnt = 0;
    model_load(nw);
    pulse_start(nw);
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == 2) pulse_start(1);
      send_word(load_words[i], gapmax);
    end
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    chk("load_done", {31'd0, done}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd0);
    chk("load_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("load_checksum", checksum, exp_sum);
    chk("load_we_count", 32'(we_cnt), 32'(n));
    chk("load_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] fibo[10] = '{32'h00000513, 32'h00100593, 32'h00A00613, 32'h00060C63,
                            32'h00B502B3, 32'h00B00533, 32'h005005B3, 32'hFFF60613,
                            32'hFEDFF06F, 32'h0000006F};

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; byte_in = '0; byte_valid = 1'b0;
    #1;
    check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single word
    load_words = '{32'h00000513};
    run_load(1, 0, 0);
    chk("t1_dir", {22'd0, last_dir}, 32'd0);

    // 2: FIBO program with imem read-back
    load_words.delete();
    foreach (fibo[i]) load_words.push_back(fibo[i]);
    run_load(10, 0, 0);
    for (int i = 0; i < 10; i++) chk("t2_readback", imem[i], fibo[i]);

    // 3: zero-length load
    begin
      bit ok = 0;
      we_cnt = 0;
      pulse_start(0);
      for (int t = 0; t < 2 && !ok; t++) begin
        @(negedge clk);
        if (done && !cpu_hold) ok = 1;
      end
      chk("t3_done_fast", {31'd0, ok}, 32'd1);
      repeat (3) @(posedge clk);
      chk("t3_no_we", 32'(we_cnt), 32'd0);
    end

    // 4: same program with random gaps and a start pulse mid-load
    run_load(10, 3, 1);

    // 5: reset after 2 bytes of the third word
    load_words.delete();
    for (int i = 0; i < 5; i++) load_words.push_back($urandom);
    model_load(5);
    pulse_start(5);
    send_word(load_words[0], 1);
    send_word(load_words[1], 1);
    send_byte(load_words[2][7:0], 0);
    send_byte(load_words[2][15:8], 0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    load_words = '{32'hA5A55A5A};
    run_load(1, 0, 0);
    chk("t5_dir", {22'd0, last_dir}, 32'd0);

    // 6: over-capacity request clamps to 256 words
    load_words.delete();
    for (int i = 0; i < 300; i++) load_words.push_back($urandom);
    run_load(300, 0, 0);
    chk("t6_last_dir", {22'd0, last_dir}, 32'd1020);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
